// File: rtl/mem_req_tracker_if.sv
// mem_req_tracker_if: client request, memory bus and load-response signals of the tracker.
interface mem_req_tracker_if #(parameter int ID_W = 3);
    logic            req_valid;
    logic            req_is_store;
    logic [31:0]     req_addr;
    logic [63:0]     req_data;
    logic [ID_W-1:0] req_id;
    logic            req_ready;
    logic [1:0]      proc2mem_command;
    logic [31:0]     proc2mem_addr;
    logic [63:0]     proc2mem_data;
    logic [3:0]      mem2proc_response;
    logic [63:0]     mem2proc_data;
    logic [3:0]      mem2proc_tag;
    logic            resp_valid;
    logic [ID_W-1:0] resp_id;
    logic [63:0]     resp_data;
    modport master (
        output req_valid, req_is_store, req_addr, req_data, req_id,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  req_ready, proc2mem_command, proc2mem_addr, proc2mem_data,
        input  resp_valid, resp_id, resp_data
    );
    modport slave (
        input  req_valid, req_is_store, req_addr, req_data, req_id,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output req_ready, proc2mem_command, proc2mem_addr, proc2mem_data,
        output resp_valid, resp_id, resp_data
    );
endinterface

// File: rtl/mem_req_tracker.sv
// mem_req_tracker: single-entry issue register feeding a tagged memory bus, with a table tracking outstanding loads.
module mem_req_tracker #(
    parameter int NUM_ENTRIES = 4,
    parameter int ID_W = 3
) (
    input  logic                           clock,
    input  logic                           reset,
    mem_req_tracker_if.slave               bus,
    output logic [$clog2(NUM_ENTRIES):0]   outstanding,
    output logic                           err_unmatched
);
    localparam int IW = $clog2(NUM_ENTRIES);
    localparam int CW = IW + 1;
    typedef enum logic [1:0] {BUS_NONE = 2'd0, BUS_LOAD = 2'd1, BUS_STORE = 2'd2} bus_cmd_e;
    logic                   issue_valid_q, issue_valid_d;
    logic                   issue_store_q, issue_store_d;
    logic [31:3]            issue_addr_q, issue_addr_d;
    logic [63:0]            issue_data_q, issue_data_d;
    logic [ID_W-1:0]        issue_id_q, issue_id_d;
    logic [NUM_ENTRIES-1:0] ent_valid_q, ent_valid_d;
    logic [3:0]             ent_tag_q [NUM_ENTRIES];
    logic [3:0]             ent_tag_d [NUM_ENTRIES];
    logic [ID_W-1:0]        ent_id_q [NUM_ENTRIES];
    logic [ID_W-1:0]        ent_id_d [NUM_ENTRIES];
    logic                   resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]        resp_id_q, resp_id_d;
    logic [63:0]            resp_data_q, resp_data_d;
    logic                   err_q, err_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   free_any, hit, accept, alloc, ready;
    logic [IW-1:0]          free_idx, hit_idx;
    bus_cmd_e               cmd;
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        hit = 1'b0;
        hit_idx = '0;
        // Descending scans so the lowest matching index wins.
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!ent_valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
            if (ent_valid_q[i] && bus.mem2proc_tag != 4'd0 && ent_tag_q[i] == bus.mem2proc_tag) begin
                hit = 1'b1;
                hit_idx = IW'(i);
            end
        end
        cmd = !issue_valid_q ? BUS_NONE : issue_store_q ? BUS_STORE : free_any ? BUS_LOAD : BUS_NONE;
        accept = cmd != BUS_NONE && bus.mem2proc_response != 4'd0;
        alloc = accept && !issue_store_q;
        ready = !issue_valid_q && !reset;
        issue_valid_d = accept ? 1'b0 : issue_valid_q;
        issue_store_d = issue_store_q;
        issue_addr_d = issue_addr_q;
        issue_data_d = issue_data_q;
        issue_id_d = issue_id_q;
        if (bus.req_valid && ready) begin
            issue_valid_d = 1'b1;
            issue_store_d = bus.req_is_store;
            issue_addr_d = bus.req_addr[31:3];
            issue_data_d = bus.req_data;
            issue_id_d = bus.req_id;
        end
        ent_valid_d = ent_valid_q;
        ent_tag_d = ent_tag_q;
        ent_id_d = ent_id_q;
        if (hit) ent_valid_d[hit_idx] = 1'b0;
        if (alloc) begin
            ent_valid_d[free_idx] = 1'b1;
            ent_tag_d[free_idx] = bus.mem2proc_response;
            ent_id_d[free_idx] = issue_id_q;
        end
        resp_valid_d = hit;
        resp_id_d = hit ? ent_id_q[hit_idx] : resp_id_q;
        resp_data_d = hit ? bus.mem2proc_data : resp_data_q;
        err_d = err_q || (bus.mem2proc_tag != 4'd0 && !hit);
        cnt_d = cnt_q + CW'(alloc) - CW'(hit);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            issue_valid_q <= 1'b0;
            issue_store_q <= 1'b0;
            issue_addr_q <= '0;
            issue_data_q <= '0;
            issue_id_q <= '0;
            ent_valid_q <= '0;
            ent_tag_q <= '{default: '0};
            ent_id_q <= '{default: '0};
            resp_valid_q <= 1'b0;
            resp_id_q <= '0;
            resp_data_q <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_store_q <= issue_store_d;
            issue_addr_q <= issue_addr_d;
            issue_data_q <= issue_data_d;
            issue_id_q <= issue_id_d;
            ent_valid_q <= ent_valid_d;
            ent_tag_q <= ent_tag_d;
            ent_id_q <= ent_id_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q <= resp_id_d;
            resp_data_q <= resp_data_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end
    assign bus.req_ready = ready;
    assign bus.proc2mem_command = cmd;
    assign bus.proc2mem_addr = {issue_addr_q, 3'b000};
    assign bus.proc2mem_data = cmd == BUS_STORE ? issue_data_q : 64'd0;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id = resp_id_q;
    assign bus.resp_data = resp_data_q;
    assign outstanding = cnt_q;
    assign err_unmatched = err_q;
endmodule

// File: tb/tb_mem_req_tracker.sv
// tb_mem_req_tracker: scenario tasks drive the tracker; a scoreboard of expected load responses is checked as responses emerge.
module tb_mem_req_tracker;
    localparam int N = 4;
    localparam int IDW = 3;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] outstanding;
    logic err;
    int checks = 0;
    int errors = 0;
    int resp_cnt = 0;
    logic [IDW+63:0] sb[$];
    logic live[16];
    logic [IDW-1:0] id_map[16];
    always #5 clk = ~clk;
    mem_req_tracker_if #(.ID_W(IDW)) bus();
    mem_req_tracker #(.NUM_ENTRIES(N), .ID_W(IDW)) dut (
        .clock(clk), .reset(rst), .bus(bus), .outstanding(outstanding), .err_unmatched(err)
    );
    // Response monitor: every resp_valid pulse must match the oldest expected response.
    initial forever begin
        logic [IDW+63:0] exp;
        @(posedge clk);
        #2;
        if (bus.resp_valid === 1'b1) begin
            resp_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got id %0d data %h want no response", bus.resp_id, bus.resp_data);
            end else begin
                exp = sb.pop_front();
                if ({bus.resp_id, bus.resp_data} !== exp) begin
                    errors++;
                    $display("FAIL resp: got id %0d data %h want id %0d data %h",
                             bus.resp_id, bus.resp_data, exp[IDW+63:64], exp[63:0]);
                end
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end
    task automatic idle();
        bus.req_valid = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.req_id = '0;
        bus.mem2proc_response = '0;
        bus.mem2proc_data = '0;
        bus.mem2proc_tag = '0;
    endtask
    task automatic step();
        @(negedge clk);
        idle();
    endtask
    task automatic clear_model();
        for (int i = 0; i < 16; i++) live[i] = 1'b0;
        sb.delete();
    endtask
    task automatic apply_reset();
        step();
        rst = 1'b1;
        clear_model();
        step();
        rst = 1'b0;
    endtask
    task automatic load_accept(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [3:0] tag);
        step();
        bus.req_valid = 1'b1;
        bus.req_addr = addr;
        bus.req_id = id;
        step();
        bus.mem2proc_response = tag;
        live[tag] = 1'b1;
        id_map[tag] = id;
    endtask
    task automatic ret_tag(input logic [3:0] tag, input logic [63:0] data);
        step();
        bus.mem2proc_tag = tag;
        bus.mem2proc_data = data;
        if (live[tag]) begin
            sb.push_back({id_map[tag], data});
            live[tag] = 1'b0;
        end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        idle();
        clear_model();
        @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", bus.req_ready); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rst_outstanding: got %0d want 0", outstanding); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
        checks++; if (bus.resp_id !== 3'd0 || bus.resp_data !== 64'd0) begin errors++; $display("FAIL rst_resp: got %0d/%h want 0/0", bus.resp_id, bus.resp_data); end
        checks++; if (bus.proc2mem_command !== 2'd0) begin errors++; $display("FAIL rst_cmd: got %0d want 0", bus.proc2mem_command); end
        checks++; if (bus.proc2mem_addr !== 32'd0 || bus.proc2mem_data !== 64'd0) begin errors++; $display("FAIL rst_bus: got %h/%h want 0/0", bus.proc2mem_addr, bus.proc2mem_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", bus.req_ready); end
    endtask
    task automatic test_load();
        int r0 = resp_cnt;
        step();
        bus.req_valid = 1'b1;
        bus.req_addr = 32'h104;
        bus.req_id = 3'd5;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b want 1", bus.req_ready); end
        step();
        #1;
        checks++; if (bus.proc2mem_command !== 2'd1 || bus.proc2mem_addr !== 32'h100 || bus.proc2mem_data !== 64'd0)
            begin errors++; $display("FAIL load_bus1: got %0d/%h/%h want 1/100/0", bus.proc2mem_command, bus.proc2mem_addr, bus.proc2mem_data); end
        step();
        #1;
        checks++; if (bus.proc2mem_command !== 2'd1) begin errors++; $display("FAIL load_bus2: got %0d want 1", bus.proc2mem_command); end
        step();
        bus.mem2proc_response = 4'd3;
        live[3] = 1'b1;
        id_map[3] = 3'd5;
        #1;
        checks++; if (bus.proc2mem_command !== 2'd1 || bus.proc2mem_addr !== 32'h100) begin errors++; $display("FAIL load_bus3: got %0d/%h want 1/100", bus.proc2mem_command, bus.proc2mem_addr); end
        step();
        #1;
        checks++; if (bus.proc2mem_command !== 2'd0) begin errors++; $display("FAIL load_after_accept: got %0d want 0", bus.proc2mem_command); end
        checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL load_outstanding1: got %0d want 1", outstanding); end
        ret_tag(4'd3, 64'hDEAD_BEEF_0000_0001);
        step();
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL load_outstanding0: got %0d want 0", outstanding); end
        step();
        checks++; if (resp_cnt - r0 != 1 || sb.size() != 0) begin errors++; $display("FAIL load_resp_count: got %0d pending %0d want 1 pending 0", resp_cnt - r0, sb.size()); end
    endtask
    task automatic test_store();
        int r0 = resp_cnt;
        step();
        bus.req_valid = 1'b1;
        bus.req_is_store = 1'b1;
        bus.req_addr = 32'h208;
        bus.req_data = 64'h55;
        step();
        bus.mem2proc_response = 4'd7;
        #1;
        checks++; if (bus.proc2mem_command !== 2'd2 || bus.proc2mem_addr !== 32'h208 || bus.proc2mem_data !== 64'h55)
            begin errors++; $display("FAIL store_bus: got %0d/%h/%h want 2/208/55", bus.proc2mem_command, bus.proc2mem_addr, bus.proc2mem_data); end
        step();
        #1;
        checks++; if (bus.proc2mem_command !== 2'd0 || bus.proc2mem_data !== 64'd0) begin errors++; $display("FAIL store_after: got %0d/%h want 0/0", bus.proc2mem_command, bus.proc2mem_data); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL store_outstanding: got %0d want 0", outstanding); end
        step();
        checks++; if (resp_cnt != r0) begin errors++; $display("FAIL store_resp: got %0d pulses want 0", resp_cnt - r0); end
    endtask
    task automatic test_full_ooo();
        for (int i = 0; i < 4; i++) begin
            load_accept(IDW'(i), 32'h1000 + 32'(i * 8), 4'(i + 1));
            #1;
            checks++; if (bus.proc2mem_command !== 2'd1) begin errors++; $display("FAIL full_fill%0d: got %0d want 1", i, bus.proc2mem_command); end
        end
        step();
        bus.req_valid = 1'b1;
        bus.req_addr = 32'h2000;
        bus.req_id = 3'd4;
        #1;
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_outstanding: got %0d want 4", outstanding); end
        step();
        #1;
        checks++; if (bus.req_ready !== 1'b0 || bus.proc2mem_command !== 2'd0) begin errors++; $display("FAIL full_stall: got ready %b cmd %0d want 0/0", bus.req_ready, bus.proc2mem_command); end
        ret_tag(4'd4, 64'hA4);
        #1;
        checks++; if (bus.proc2mem_command !== 2'd0) begin errors++; $display("FAIL full_free_same_cycle: got %0d want 0", bus.proc2mem_command); end
        ret_tag(4'd2, 64'hA2);
        bus.mem2proc_response = 4'd5;
        live[5] = 1'b1;
        id_map[5] = 3'd4;
        #1;
        checks++; if (bus.proc2mem_command !== 2'd1 || bus.proc2mem_addr !== 32'h2000) begin errors++; $display("FAIL full_fifth_issue: got %0d/%h want 1/2000", bus.proc2mem_command, bus.proc2mem_addr); end
        ret_tag(4'd1, 64'hA1);
        #1;
        checks++; if (bus.req_ready !== 1'b1 || outstanding !== 3'd3) begin errors++; $display("FAIL full_after_fifth: got ready %b out %0d want 1/3", bus.req_ready, outstanding); end
        ret_tag(4'd3, 64'hA3);
        ret_tag(4'd5, 64'hA5);
        step();
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL full_drain: got %0d want 0", outstanding); end
        step();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL full_pending: got %0d want 0", sb.size()); end
    endtask
    task automatic test_unmatched();
        int r0 = resp_cnt;
        step();
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL unm_before: got %b want 0", err); end
        ret_tag(4'd9, 64'h99);
        step();
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL unm_set: got %b want 1", err); end
        repeat (3) step();
        #1;
        checks++; if (err !== 1'b1 || resp_cnt != r0) begin errors++; $display("FAIL unm_hold: got err %b pulses %0d want 1/0", err, resp_cnt - r0); end
    endtask
    task automatic test_same_cycle();
        int r0;
        apply_reset();
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL same_err_cleared: got %b want 0", err); end
        r0 = resp_cnt;
        for (int i = 0; i < 4; i++) load_accept(IDW'(i), 32'h3000 + 32'(i * 8), 4'(i + 1));
        step();
        bus.req_valid = 1'b1;
        bus.req_is_store = 1'b1;
        bus.req_addr = 32'h300;
        bus.req_data = 64'h77;
        #1;
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL same_full: got %0d want 4", outstanding); end
        ret_tag(4'd2, 64'hB2);
        bus.mem2proc_response = 4'd6;
        #1;
        checks++; if (bus.proc2mem_command !== 2'd2 || bus.proc2mem_data !== 64'h77) begin errors++; $display("FAIL same_store_full: got %0d/%h want 2/77", bus.proc2mem_command, bus.proc2mem_data); end
        step();
        #1;
        checks++; if (outstanding !== 3'd3 || bus.proc2mem_command !== 2'd0) begin errors++; $display("FAIL same_after: got out %0d cmd %0d want 3/0", outstanding, bus.proc2mem_command); end
        step();
        checks++; if (resp_cnt - r0 != 1 || sb.size() != 0) begin errors++; $display("FAIL same_resp: got %0d pending %0d want 1 pending 0", resp_cnt - r0, sb.size()); end
    endtask
    task automatic test_reset_mid();
        int r0;
        apply_reset();
        load_accept(3'd1, 32'h400, 4'd1);
        load_accept(3'd2, 32'h408, 4'd2);
        step();
        #1;
        checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL mid_outstanding: got %0d want 2", outstanding); end
        step();
        rst = 1'b1;
        clear_model();
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", bus.req_ready); end
        step();
        rst = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd0 || bus.proc2mem_command !== 2'd0 || err !== 1'b0)
            begin errors++; $display("FAIL mid_after_rst: got out %0d cmd %0d err %b want 0/0/0", outstanding, bus.proc2mem_command, err); end
        r0 = resp_cnt;
        ret_tag(4'd1, 64'hC1);
        step();
        step();
        #1;
        checks++; if (err !== 1'b1 || resp_cnt != r0) begin errors++; $display("FAIL mid_stale_tag: got err %b pulses %0d want 1/0", err, resp_cnt - r0); end
    endtask
    initial begin
        test_reset();
        test_load();
        test_store();
        test_full_ooo();
        test_unmatched();
        test_same_cycle();
        test_reset_mid();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_req_tracker.md
MEM_REQ_TRACKER -- requirements
Module: mem_req_tracker

Interface
REQ-001 Parameter NUM_ENTRIES, 4, maximum number of outstanding loads (power of two, 2..8).
REQ-002 Parameter ID_W, 3, width of the client request ID.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clock  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  client offers a request.
REQ-007 req_is_store  in  1  1 = BUS_STORE, 0 = BUS_LOAD.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_data  in  64  store data; ignored for loads.
REQ-010 req_id  in  ID_W  client tag, returned with load data.
REQ-011 req_ready  out  1  request is accepted on this cycle when req_valid=1.
REQ-012 proc2mem_command  out  2  BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2.
REQ-013 proc2mem_addr  out  32  line address: {issue_addr[31:3],3'b000}.
REQ-014 proc2mem_data  out  64  store data; 0 when the command is not BUS_STORE.
REQ-015 mem2proc_response  in  4  0 = not accepted; otherwise the transaction tag.
REQ-016 mem2proc_data  in  64  load data, valid with mem2proc_tag.
REQ-017 mem2proc_tag  in  4  0 = no data; otherwise the tag of the completing load.
REQ-018 resp_valid  out  1  load data returned, registered, one-cycle pulse.
REQ-019 resp_id  out  ID_W  req_id of the completed load.
REQ-020 resp_data  out  64  64-bit line data.
REQ-021 outstanding  out  $clog2(NUM_ENTRIES)+1  count of live table entries.
REQ-022 err_unmatched  out  1  sticky; a nonzero tag arrived that matched no live entry.

Function
REQ-023 Issue register (1 entry: valid, is_store, addr, data, id); req_ready = ~issue_valid (registered, no same-cycle bypass).
REQ-024 Handshake: req_valid & req_ready loads the issue register at the clock edge; the bus is driven from the next cycle.
REQ-025 While issue_valid: drive BUS_STORE for a store; drive BUS_LOAD for a load only if a free table entry exists, else BUS_NONE. Command, address and data are held stable until accepted.
REQ-026 Acceptance: a cycle with command != BUS_NONE and mem2proc_response != 0; issue_valid clears at that edge.
REQ-027 Accepted load: allocate the lowest-index free entry {valid=1, tag=mem2proc_response, id}. An accepted store allocates nothing and completes silently.
REQ-028 Tag return: mem2proc_tag != 0 matching a live entry's tag -> entry freed at that edge; the next cycle resp_valid=1, resp_id=entry id, resp_data=captured mem2proc_data.
REQ-029 Out-of-order tag returns are supported; each match is independent of the allocation order.
REQ-030 A nonzero mem2proc_tag matching no live entry -> ignored; err_unmatched set at that edge, held until reset.
REQ-031 Same-cycle acceptance and tag return are both processed. An entry freed in cycle N is not allocatable until cycle N+1 (free-check uses registered state).
REQ-032 Table full (outstanding=NUM_ENTRIES) with a pending load: BUS_NONE, issue register held, req_ready=0; stores are unaffected by table fullness.
REQ-033 outstanding = +1 per allocation, -1 per match; both in the same cycle -> unchanged.
REQ-034 resp_valid=0 in any cycle with no match on the previous edge; resp_id/resp_data hold their last values.

Reset
REQ-035 On reset: issue_valid=0, all entries invalid, outstanding=0, resp_valid=0, resp_id=0, resp_data=0, err_unmatched=0, proc2mem_command=BUS_NONE, proc2mem_addr=0, proc2mem_data=0.
REQ-036 Reset mid-operation discards all outstanding loads without a response; tags returning after reset set err_unmatched.
REQ-037 req_ready=0 during the reset cycle and 1 in the first cycle after reset.

Verification
REQ-038 Load addr 0x104, id 5; memory responds with tag 3 after 2 BUS_LOAD cycles, then tag 3 with data 0xDEAD_BEEF_0000_0001 -> proc2mem_addr=0x100; one resp_valid pulse with id 5 and that data; outstanding returns to 0.
REQ-039 Store addr 0x208, data 0x55, response 7 -> BUS_STORE for exactly the accepting cycle, then BUS_NONE; no resp_valid; outstanding stays 0.
REQ-040 4 loads (ids 0-3) accepted with tags 1,2,3,4; a 5th load is offered -> BUS_NONE and req_ready=0; tags returned 4,2,1,3 -> responses ids 3,1,0,2 in that order; the 5th load issues the cycle after the first free.
REQ-041 Tag 9 arrives with no live entry -> no resp_valid; err_unmatched=1 until reset.
REQ-042 With the table full, tag 2 returns in the same cycle a store is accepted -> store completes, the entry is freed, and outstanding goes from 4 to 3.
REQ-043 Reset asserted with 2 loads outstanding -> outstanding=0, command BUS_NONE; a later tag for one of those loads -> err_unmatched=1, no resp_valid.
